// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned REG_AW       = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_MDU  = 2'd2
  } wr_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of MDU results (rd + data) with per-entry visibility for hazard checks.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DW    = DEFAULT_XLEN,
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [REG_AW-1:0]             push_rd,
  input  logic [DW-1:0]                 push_data,
  output logic [REG_AW-1:0]             head_rd,
  output logic [DW-1:0]                 head_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0]     data_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && (count < CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
      entry_rd[i]    = rd_mem[i];
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, buffered MDU results fill free slots.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = DEFAULT_XLEN,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RegWriteW,
  input  logic [REG_AW-1:0]   RdW,
  input  logic [XLEN-1:0]     ResultW,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [REG_AW-1:0]   mdu_rd,
  input  logic [XLEN-1:0]     mdu_result,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_addr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                wb_hold,
  output logic [31:0]         pend_mask
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                                    slot_busy;
  logic                                    fifo_empty;
  logic                                    push;
  logic                                    pop;
  logic [REG_AW-1:0]                       head_rd;
  logic [XLEN-1:0]                         head_data;
  logic [CW-1:0]                           count;
  logic [FIFO_DEPTH-1:0]                   entry_valid;
  logic [FIFO_DEPTH-1:0][REG_AW-1:0]       entry_rd;
  logic [3:0]                              starve_cnt;
  wr_src_e                                 src;

  assign slot_busy  = RegWriteW && (RdW != REG_ZERO);
  assign fifo_empty = (count == '0);
  assign mdu_ready  = !rst && (count < CW'(FIFO_DEPTH));
  // x0 results complete the handshake but are dropped here.
  assign push       = mdu_valid && mdu_ready && (mdu_rd != REG_ZERO);
  assign pop        = (src == SRC_MDU);

  wb_result_fifo #(
    .DW    (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_rd     (mdu_rd),
    .push_data   (mdu_result),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  always_comb begin
    src = SRC_NONE;
    if (!rst) begin
      if (slot_busy)        src = SRC_PIPE;
      else if (!fifo_empty) src = SRC_MDU;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = REG_ZERO;
    rf_wdata = '0;
    unique case (src)
      SRC_PIPE: begin
        rf_we    = 1'b1;
        rf_addr  = RdW;
        rf_wdata = ResultW;
      end
      SRC_MDU: begin
        rf_we    = 1'b1;
        rf_addr  = head_rd;
        rf_wdata = head_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (slot_busy && (starve_cnt != 4'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign wb_hold = (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) pend_mask[entry_rd[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: register-file writes checked through a scoreboard queue.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_result;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        wb_hold;
  logic [31:0] pend_mask;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  wb_port_arbiter #(
    .XLEN         (32),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_rd     (mdu_rd),
    .mdu_result (mdu_result),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .wb_hold    (wb_hold),
    .pend_mask  (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_exp(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Drives one cycle of inputs; a busy pipeline slot is expected to write this cycle.
  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
    RegWriteW  = we;
    RdW        = rd;
    ResultW    = res;
    mdu_valid  = mv;
    mdu_rd     = mrd;
    mdu_result = mres;
    if (we && rd != 5'd0) sb_exp(rd, res);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write at %0t",
                 rf_addr, rf_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_addr !== e.a || rf_wdata !== e.d) begin
          bad++;
          $display("FAIL rf_write: got addr=%0d data=%h expected addr=%0d data=%h at %0t",
                   rf_addr, rf_wdata, e.a, e.d, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("rst_ready", {31'b0, mdu_ready}, 32'd0);
    chk("rst_we", {31'b0, rf_we}, 32'd0);
    chk("rst_hold", {31'b0, wb_hold}, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    #6 rst = 1'b0;
    tick;

    // pipeline-only write, same cycle
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    chk("pipe_ready", {31'b0, mdu_ready}, 32'd1);
    chk("pipe_hold", {31'b0, wb_hold}, 32'd0);
    tick;

    // MDU result drains into a free slot the next cycle
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12);
    #1 chk("drain_pend_before", pend_mask, 32'd0);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sb_exp(5'd7, 32'h12);
    #1 chk("drain_pend_during", pend_mask, 32'h80);
    tick;
    chk("drain_pend_after", pend_mask, 32'd0);

    // full FIFO and backpressure under a continuously busy pipeline
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd8, 32'h88);
    tick;
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd9, 32'h99);
    tick;
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd10, 32'hAA);
    #1;
    chk("full_ready", {31'b0, mdu_ready}, 32'd0);
    chk("full_pend", pend_mask, 32'h300);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hAA);
    sb_exp(5'd8, 32'h88);
    #1 chk("pop_cycle_ready", {31'b0, mdu_ready}, 32'd0);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hAA);
    sb_exp(5'd9, 32'h99);
    #1;
    chk("after_pop_ready", {31'b0, mdu_ready}, 32'd1);
    chk("pushpop_pend", pend_mask, 32'h200);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sb_exp(5'd10, 32'hAA);
    #1 chk("wrap_pend", pend_mask, 32'h400);
    tick;
    chk("full_done_pend", pend_mask, 32'd0);

    // starvation: one entry behind a busy pipeline
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'hBB);
    tick;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
      #1 chk($sformatf("starve_hold_%0d", k), {31'b0, wb_hold}, (k >= 5) ? 32'd1 : 32'd0);
      tick;
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sb_exp(5'd11, 32'hBB);
    #1 chk("bubble_hold", {31'b0, wb_hold}, 32'd1);
    tick;
    chk("hold_cleared", {31'b0, wb_hold}, 32'd0);

    // x0 handling
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    #1 chk("x0_ready", {31'b0, mdu_ready}, 32'd1);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 chk("x0_pend", pend_mask, 32'd0);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hCC);
    tick;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    sb_exp(5'd12, 32'hCC);
    #1 chk("rd0_free_pend", pend_mask, 32'h1000);
    tick;
    chk("rd0_done_pend", pend_mask, 32'd0);

    // asynchronous reset with two buffered entries
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd13, 32'hD1);
    tick;
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd14, 32'hE1);
    tick;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 chk("prerst_pend", pend_mask, 32'h6000);
    rst = 1'b1;
    #1;
    chk("arst_we", {31'b0, rf_we}, 32'd0);
    chk("arst_ready", {31'b0, mdu_ready}, 32'd0);
    chk("arst_hold", {31'b0, wb_hold}, 32'd0);
    chk("arst_pend", pend_mask, 32'd0);
    #4 rst = 1'b0;
    tick;
    chk("postrst_ready", {31'b0, mdu_ready}, 32'd1);
    chk("postrst_pend", pend_mask, 32'd0);
    tick;
    tick;

    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
